// File: rtl/spwm_deadtime_pkg.sv
// Shared definitions for the SPWM gate-drive slice: FSM state encoding and
// dead-time defaults.
package spwm_deadtime_pkg;

    localparam int DT_W = 8;
    localparam logic [DT_W-1:0] DT_RESET = 8'd10;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        DT_TO_H = 3'd1,
        H_ON    = 3'd2,
        DT_TO_L = 3'd3,
        L_ON    = 3'd4
    } state_t;

endpackage

// File: rtl/spwm_dt_counter.sv
// Dead-time down-counter: clear beats load beats decrement; it saturates at
// zero and reports it through a zero flag.
module spwm_dt_counter #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    input  logic            dec,
    output logic            zero
);

    logic [DT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - {{(DT_W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/spwm_deadtime.sv
// Complementary half-bridge gate driver with programmable dead time, fed by
// the single-ended SPWM comparator bit.
module spwm_deadtime
    import spwm_deadtime_pkg::*;
#(
    parameter int              DT_W     = spwm_deadtime_pkg::DT_W,
    parameter logic [DT_W-1:0] DT_RESET = spwm_deadtime_pkg::DT_RESET
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            dead_time_ld,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            in_dead
);

    state_t          state;
    logic            pwm_r;
    logic [DT_W-1:0] dt_reg;
    logic [DT_W-1:0] dt_eff;
    logic [DT_W-1:0] dt_load;
    logic            go_h;
    logic            go_l;
    logic            cnt_dec;
    logic            cnt_load;
    logic            cnt_zero;

    // pwm_in may be combinational and glitchy; every decision uses this copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= pwm_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dt_reg <= DT_RESET;
        end else if (dead_time_ld) begin
            dt_reg <= dead_time;
        end
    end

    // A zero request still yields one dead cycle; the counter holds DT-1.
    assign dt_eff  = (dt_reg == '0) ? {{(DT_W-1){1'b0}}, 1'b1} : dt_reg;
    assign dt_load = dt_eff - {{(DT_W-1){1'b0}}, 1'b1};

    always_comb begin
        go_h    = 1'b0;
        go_l    = 1'b0;
        cnt_dec = 1'b0;
        case (state)
            OFF: begin
                go_h = pwm_r;
                go_l = !pwm_r;
            end
            DT_TO_H: begin
                go_l    = !pwm_r;
                cnt_dec = pwm_r;
            end
            H_ON:    go_l = !pwm_r;
            DT_TO_L: begin
                go_h    = pwm_r;
                cnt_dec = !pwm_r;
            end
            L_ON:    go_h = pwm_r;
            default: ;
        endcase
    end

    // Any entry into a dead interval (including a reversal mid-interval)
    // reloads the full count.
    assign cnt_load = en && (go_h || go_l);

    spwm_dt_counter #(
        .DT_W (DT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!en),
        .load     (cnt_load),
        .load_val (dt_load),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // A gate only rises from a dead state, where both gates are already low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= OFF;
            pwm_h   <= 1'b0;
            pwm_l   <= 1'b0;
            in_dead <= 1'b0;
        end else if (!en) begin
            state   <= OFF;
            pwm_h   <= 1'b0;
            pwm_l   <= 1'b0;
            in_dead <= 1'b0;
        end else if (go_h) begin
            state   <= DT_TO_H;
            pwm_h   <= 1'b0;
            pwm_l   <= 1'b0;
            in_dead <= 1'b1;
        end else if (go_l) begin
            state   <= DT_TO_L;
            pwm_h   <= 1'b0;
            pwm_l   <= 1'b0;
            in_dead <= 1'b1;
        end else begin
            case (state)
                DT_TO_H: begin
                    if (cnt_zero) begin
                        state   <= H_ON;
                        pwm_h   <= 1'b1;
                        pwm_l   <= 1'b0;
                        in_dead <= 1'b0;
                    end
                end
                DT_TO_L: begin
                    if (cnt_zero) begin
                        state   <= L_ON;
                        pwm_h   <= 1'b0;
                        pwm_l   <= 1'b1;
                        in_dead <= 1'b0;
                    end
                end
                OFF, H_ON, L_ON: ;
                default: begin
                    state   <= OFF;
                    pwm_h   <= 1'b0;
                    pwm_l   <= 1'b0;
                    in_dead <= 1'b0;
                end
            endcase
        end
    end

endmodule
